// File: rtl/issue_select_if.sv
// Bundle for issue_select: RS request side, RS read enables and the per-FU issue slots.
// The FU/RS environment drives through master; the select stage sits on slave.
interface issue_select_if #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned NUM_FU  = 2,
  parameter int unsigned PKT_W   = 64
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][PKT_W-1:0] req_pkt;
  logic [NUM_FU-1:0]             fu_ready;
  logic [NUM_REQ-1:0]            rs_rd_en;
  logic [NUM_FU-1:0]             iss_valid;
  logic [NUM_FU-1:0][PKT_W-1:0]  iss_pkt;

  modport master (
    output req_valid, req_pkt, fu_ready,
    input  rs_rd_en, iss_valid, iss_pkt
  );

  modport slave (
    input  req_valid, req_pkt, fu_ready,
    output rs_rd_en, iss_valid, iss_pkt
  );
endinterface

// File: rtl/issue_select.sv
// Round-robin issue select: picks up to NUM_FU ready RS entries per cycle into
// per-FU output registers that hold until the FU accepts, with squash flush.
module issue_select #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned NUM_FU  = 2,
  parameter int unsigned PKT_W   = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  issue_select_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic [PtrW:0] NumReqW = (PtrW + 1)'(NUM_REQ);

  logic [PtrW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0]            iss_valid_q, iss_valid_d;
  logic [NUM_FU-1:0][PKT_W-1:0] iss_pkt_q, iss_pkt_d;

  logic [NUM_FU-1:0]            slot_free;
  logic [NUM_FU-1:0]            slot_grant;
  logic [NUM_FU-1:0][PtrW-1:0]  slot_src;
  logic [NUM_REQ-1:0]           rd_en;

  logic [PtrW:0]   sum_w;
  logic [PtrW:0]   nxt_w;
  logic [PtrW-1:0] cur;
  logic            placed;

  // A slot is free if empty or its occupant is leaving at this edge.
  always_comb begin
    slot_free = ~iss_valid_q | bus.fu_ready;
  end

  // Scan requesters from rr_ptr; each valid one takes the lowest still-unfilled free slot.
  always_comb begin
    rd_en      = '0;
    slot_grant = '0;
    slot_src   = '0;
    rr_ptr_d   = rr_ptr_q;
    sum_w      = '0;
    nxt_w      = '0;
    cur        = '0;
    placed     = 1'b0;
    if (!reset && !squash) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sum_w = {1'b0, rr_ptr_q} + (PtrW + 1)'(k);
        cur   = (sum_w >= NumReqW) ? PtrW'(sum_w - NumReqW) : sum_w[PtrW-1:0];
        if (bus.req_valid[cur]) begin
          placed = 1'b0;
          for (int unsigned j = 0; j < NUM_FU; j++) begin
            if (!placed && slot_free[j] && !slot_grant[j]) begin
              placed        = 1'b1;
              slot_grant[j] = 1'b1;
              slot_src[j]   = cur;
              rd_en[cur]    = 1'b1;
              nxt_w         = {1'b0, cur} + (PtrW + 1)'(1);
              rr_ptr_d      = (nxt_w >= NumReqW) ? '0 : nxt_w[PtrW-1:0];
            end
          end
        end
      end
    end
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_pkt_d   = iss_pkt_q;
    for (int unsigned j = 0; j < NUM_FU; j++) begin
      if (squash) begin
        iss_valid_d[j] = 1'b0;
      end else if (slot_free[j]) begin
        iss_valid_d[j] = slot_grant[j];
        if (slot_grant[j]) begin
          iss_pkt_d[j] = bus.req_pkt[slot_src[j]];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      iss_valid_q <= '0;
      iss_pkt_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_pkt_q   <= iss_pkt_d;
    end
  end

  assign bus.rs_rd_en  = rd_en;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_pkt   = iss_pkt_q;

endmodule

// File: tb/tb_issue_select.sv
// Self-checking bench for issue_select: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_issue_select;

  localparam int unsigned NR = 8;
  localparam int unsigned NF = 2;
  localparam int unsigned PW = 64;

  logic clock;
  logic reset;
  logic squash;

  issue_select_if #(.NUM_REQ(NR), .NUM_FU(NF), .PKT_W(PW)) bus ();

  issue_select #(.NUM_REQ(NR), .NUM_FU(NF), .PKT_W(PW)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [PW-1:0] drv_pkt [NR];

  // Reference model state
  logic [NF-1:0] m_valid;
  logic [PW-1:0] m_pkt [NF];
  int unsigned   m_ptr;
  logic          m_known = 1'b0;
  logic [NR-1:0] exp_rd_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after negedge, compare against model, advance model.
  task automatic step(input logic [NR-1:0] rv, input logic [NF-1:0] fr,
                      input logic sq, input logic rs);
    int unsigned q_req[$];
    int unsigned q_free[$];
    int unsigned n;
    @(negedge clock);
    bus.req_valid = rv;
    bus.fu_ready  = fr;
    squash        = sq;
    reset         = rs;
    for (int i = 0; i < NR; i++) begin
      drv_pkt[i]     = {$urandom(), $urandom()};
      bus.req_pkt[i] = drv_pkt[i];
    end
    #1;
    exp_rd_en = '0;
    n = 0;
    if (!rs && !sq && m_known) begin
      for (int unsigned k = 0; k < NR; k++) begin
        if (rv[(m_ptr + k) % NR]) q_req.push_back((m_ptr + k) % NR);
      end
      for (int unsigned j = 0; j < NF; j++) begin
        if (!m_valid[j] || fr[j]) q_free.push_back(j);
      end
      n = (q_req.size() < q_free.size()) ? q_req.size() : q_free.size();
      for (int unsigned g = 0; g < n; g++) exp_rd_en[q_req[g]] = 1'b1;
    end
    if (m_known || rs) chk("rs_rd_en", 64'(bus.rs_rd_en), 64'(exp_rd_en));
    if (m_known) begin
      chk("iss_valid", 64'(bus.iss_valid), 64'(m_valid));
      for (int j = 0; j < NF; j++) begin
        if (m_valid[j]) chk($sformatf("iss_pkt[%0d]", j), bus.iss_pkt[j], m_pkt[j]);
      end
    end
    if (rs) begin
      m_valid = '0;
      m_ptr   = 0;
      m_known = 1'b1;
    end else if (sq) begin
      m_valid = '0;
    end else begin
      foreach (q_free[f]) m_valid[q_free[f]] = 1'b0;
      for (int unsigned g = 0; g < n; g++) begin
        m_valid[q_free[g]] = 1'b1;
        m_pkt[q_free[g]]   = drv_pkt[q_req[g]];
      end
      if (n > 0) m_ptr = (q_req[n-1] + 1) % NR;
    end
  endtask

  logic [PW-1:0] p0, p1, p7;

  initial begin
    reset         = 1'b1;
    squash        = 1'b0;
    bus.req_valid = '0;
    bus.fu_ready  = '0;
    bus.req_pkt   = '0;

    // Reset with everything requesting
    step(8'hFF, 2'b11, 1'b0, 1'b1);
    chk("reset rd_en c0", 64'(bus.rs_rd_en), 64'h0);
    step(8'hFF, 2'b11, 1'b0, 1'b1);
    chk("reset rd_en c1", 64'(bus.rs_rd_en), 64'h0);
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("post-reset iss_valid", 64'(bus.iss_valid), 64'h0);
    chk("post-reset iss_pkt0", bus.iss_pkt[0], 64'h0);
    chk("first grants", 64'(bus.rs_rd_en), 64'h03);
    p0 = drv_pkt[0];
    p1 = drv_pkt[1];

    // Round-robin fairness
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("rr grants 2,3", 64'(bus.rs_rd_en), 64'h0C);
    chk("rr pkt slot0", bus.iss_pkt[0], p0);
    chk("rr pkt slot1", bus.iss_pkt[1], p1);
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("rr grants 4,5", 64'(bus.rs_rd_en), 64'h30);
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("rr grants 6,7", 64'(bus.rs_rd_en), 64'hC0);
    p7 = drv_pkt[7];
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("rr wrap 0,1", 64'(bus.rs_rd_en), 64'h03);
    chk("rr pkt slot1 e7", bus.iss_pkt[1], p7);
    p1 = drv_pkt[1];

    // Back-pressure: only slot 0 drains
    step(8'h30, 2'b01, 1'b0, 1'b0);
    chk("bp grant 4", 64'(bus.rs_rd_en), 64'h10);
    for (int c = 0; c < 3; c++) begin
      step(8'h30, 2'b00, 1'b0, 1'b0);
      chk("bp stall rd_en", 64'(bus.rs_rd_en), 64'h0);
      chk("bp slot1 held", bus.iss_pkt[1], p1);
    end
    step(8'h30, 2'b10, 1'b0, 1'b0);
    chk("bp grant 5", 64'(bus.rs_rd_en), 64'h20);

    // Sparse wrap from rr_ptr=6
    step(8'h81, 2'b11, 1'b0, 1'b0);
    chk("sparse 7,0", 64'(bus.rs_rd_en), 64'h81);
    p7 = drv_pkt[7];
    p0 = drv_pkt[0];
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("sparse ptr=1", 64'(bus.rs_rd_en), 64'h06);
    chk("sparse slot0 e7", bus.iss_pkt[0], p7);
    chk("sparse slot1 e0", bus.iss_pkt[1], p0);

    // Squash with both slots valid
    step(8'hFF, 2'b11, 1'b1, 1'b0);
    chk("squash rd_en", 64'(bus.rs_rd_en), 64'h0);
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("squash cleared", 64'(bus.iss_valid), 64'h0);
    chk("squash ptr held", 64'(bus.rs_rd_en), 64'h18);
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("squash resumed", 64'(bus.iss_valid), 64'h3);

    // Reset in the middle of a stall
    step(8'hFF, 2'b00, 1'b0, 1'b0);
    chk("stall no grant", 64'(bus.rs_rd_en), 64'h0);
    step(8'hFF, 2'b00, 1'b0, 1'b1);
    step(8'hFF, 2'b11, 1'b0, 1'b0);
    chk("midstall valid", 64'(bus.iss_valid), 64'h0);
    chk("midstall ptr", 64'(bus.rs_rd_en), 64'h03);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(8'($urandom()), 2'($urandom()), ($urandom_range(15) == 0),
           ($urandom_range(199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
